// File: rtl/dot_scan_controller.sv
// Walks a rectangular dot window, sampling firing bits and emitting timed drive pulses.
// Optional SCAN_LOOP_EN: latch the loop input at start and repeat the window until stop.
module dot_scan_controller #(
  parameter int MEM_LENGTH         = 48,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int TIME_WIDTH         = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop,
  input  logic                          sel_mode,
  input  logic [MEM_ADDRESS_LENGTH-1:0] row_first,
  input  logic [MEM_ADDRESS_LENGTH-1:0] row_last,
  input  logic [MEM_ADDRESS_LENGTH-1:0] col_first,
  input  logic [MEM_ADDRESS_LENGTH-1:0] col_last,
  input  logic [TIME_WIDTH-1:0]         pulse_cycles,
  input  logic [TIME_WIDTH-1:0]         dwell_cycles,
  input  logic                          firing_bit,
  input  logic                          firing_data,
  output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
  output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
  output logic                          row_col_select,
  output logic                          drive_en,
  output logic                          drive_level,
  output logic                          dot_strobe,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_FIRE, S_GAP, S_ADVANCE, S_DONE
  } state_t;

  state_t                        state, state_n;
  logic [MEM_ADDRESS_LENGTH-1:0] row_first_q, row_last_q, col_first_q, col_last_q;
  logic [TIME_WIDTH-1:0]         pulse_q, dwell_q, cnt, cnt_n;
  logic [MEM_ADDRESS_LENGTH-1:0] row_n, col_n;
  logic                          cap_bit, cap_data, cap_bit_n, cap_data_n;
  logic                          drive_en_n, drive_level_n, cfg_err_n;
  logic                          latch, window_ok, loop_act;

`ifdef SCAN_LOOP_EN
  logic loop_q;
  always_ff @(posedge clock) begin
    if (reset)      loop_q <= 1'b0;
    else if (latch) loop_q <= loop;
  end
  assign loop_act = loop_q;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_act    = 1'b0;
`endif

  assign window_ok = (row_first <= row_last) && (int'(row_last) < MEM_LENGTH) &&
                     (col_first <= col_last) && (int'(col_last) < MEM_LENGTH);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    row_n      = row_select;
    col_n      = col_select;
    cap_bit_n  = cap_bit;
    cap_data_n = cap_data;
    cfg_err_n  = 1'b0;
    latch      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          if (window_ok) begin
            latch   = 1'b1;
            row_n   = row_first;
            col_n   = col_first;
            state_n = S_SAMPLE;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      S_SAMPLE: begin
        cap_bit_n  = firing_bit;
        cap_data_n = firing_data;
        if (pulse_q == '0) begin
          state_n = S_GAP;
          cnt_n   = dwell_q;
        end else begin
          state_n = S_FIRE;
          cnt_n   = pulse_q;
        end
      end
      S_FIRE: begin
        if (cnt <= TIME_WIDTH'(1)) begin
          state_n = S_GAP;
          cnt_n   = dwell_q;
        end else begin
          cnt_n = cnt - TIME_WIDTH'(1);
        end
      end
      // A zero dwell still spends one cycle here, so the gap is max(dwell, 1).
      S_GAP: begin
        if (cnt <= TIME_WIDTH'(1)) state_n = S_ADVANCE;
        else                       cnt_n   = cnt - TIME_WIDTH'(1);
      end
      S_ADVANCE: begin
        state_n = S_SAMPLE;
        if (col_select != col_last_q) begin
          col_n = col_select + MEM_ADDRESS_LENGTH'(1);
        end else if (row_select != row_last_q) begin
          col_n = col_first_q;
          row_n = row_select + MEM_ADDRESS_LENGTH'(1);
        end else if (loop_act) begin
          row_n = row_first_q;
          col_n = col_first_q;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Abort wins over every transition and freezes the address where it was.
    if (stop && state != S_IDLE) begin
      state_n = S_IDLE;
      row_n   = row_select;
      col_n   = col_select;
    end
    drive_en_n    = (state_n == S_FIRE) && cap_bit_n;
    drive_level_n = drive_en_n && cap_data_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      row_select     <= '0;
      col_select     <= '0;
      cap_bit        <= 1'b0;
      cap_data       <= 1'b0;
      drive_en       <= 1'b0;
      drive_level    <= 1'b0;
      cfg_err        <= 1'b0;
      row_col_select <= 1'b0;
      row_first_q    <= '0;
      row_last_q     <= '0;
      col_first_q    <= '0;
      col_last_q     <= '0;
      pulse_q        <= '0;
      dwell_q        <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      row_select  <= row_n;
      col_select  <= col_n;
      cap_bit     <= cap_bit_n;
      cap_data    <= cap_data_n;
      drive_en    <= drive_en_n;
      drive_level <= drive_level_n;
      cfg_err     <= cfg_err_n;
      if (latch) begin
        row_col_select <= sel_mode;
        row_first_q    <= row_first;
        row_last_q     <= row_last;
        col_first_q    <= col_first;
        col_last_q     <= col_last;
        pulse_q        <= pulse_cycles;
        dwell_q        <= dwell_cycles;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign dot_strobe = (state == S_SAMPLE);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_dot_scan_controller.sv
// Randomized bench for dot_scan_controller: per-cycle expected outputs are derived
// from the window/timing rules and compared against the DUT.
module tb_dot_scan_controller;

`ifdef SCAN_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, start, stop, loop, sel_mode;
  logic [5:0]  row_first, row_last, col_first, col_last;
  logic [15:0] pulse_cycles, dwell_cycles;
  logic        firing_bit, firing_data;
  logic [5:0]  row_select, col_select;
  logic        row_col_select, drive_en, drive_level, dot_strobe, busy, done, cfg_err;

  logic        bit_mem  [64][64];
  logic        data_mem [64][64];

  int          n_vec = 0;
  int          n_err = 0;
  logic [5:0]  last_row, last_col;
  logic        last_rcs;
  logic [18:0] exp_q[$];

  always #5 clock = ~clock;

  assign firing_bit  = bit_mem[row_select][col_select];
  assign firing_data = data_mem[row_select][col_select];

  dot_scan_controller #(
    .MEM_LENGTH(48), .MEM_ADDRESS_LENGTH(6), .TIME_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .sel_mode(sel_mode), .row_first(row_first), .row_last(row_last),
    .col_first(col_first), .col_last(col_last), .pulse_cycles(pulse_cycles),
    .dwell_cycles(dwell_cycles), .firing_bit(firing_bit), .firing_data(firing_data),
    .row_select(row_select), .col_select(col_select), .row_col_select(row_col_select),
    .drive_en(drive_en), .drive_level(drive_level), .dot_strobe(dot_strobe),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {cfg_err, busy, dot_strobe, drive_en, drive_level, done, row_col_select, row, col}
  function automatic logic [18:0] vec(input logic ce, input logic bz, input logic st,
                                      input logic en, input logic lv, input logic dn,
                                      input logic rcs, input logic [5:0] r, input logic [5:0] c);
    return {ce, bz, st, en, lv, dn, rcs, r, c};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {cfg_err, busy, dot_strobe, drive_en, drive_level, done, row_col_select,
            row_select, col_select};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble();
    row_first    = 6'($urandom);
    row_last     = 6'($urandom);
    col_first    = 6'($urandom);
    col_last     = 6'($urandom);
    pulse_cycles = 16'($urandom);
    dwell_cycles = 16'($urandom);
    sel_mode     = 1'($urandom);
    loop         = 1'($urandom);
    start        = 1'($urandom);
  endtask

  // Expected trace: per dot SAMPLE, pulse cycles, max(dwell,1) gap cycles, ADVANCE.
  function automatic void build(input int rf, input int rl, input int cf, input int cl,
                                input int p, input int d, input logic sm, input int passes,
                                input bit with_done);
    int gap;
    gap = (d > 1) ? d : 1;
    exp_q.delete();
    for (int n = 0; n < passes; n++)
      for (int r = rf; r <= rl; r++)
        for (int c = cf; c <= cl; c++) begin
          logic b, dd;
          b  = bit_mem[r][c];
          dd = data_mem[r][c];
          exp_q.push_back(vec(0, 1, 1, 0, 0, 0, sm, 6'(r), 6'(c)));
          for (int k = 0; k < p; k++) exp_q.push_back(vec(0, 1, 0, b, b & dd, 0, sm, 6'(r), 6'(c)));
          for (int k = 0; k < gap; k++) exp_q.push_back(vec(0, 1, 0, 0, 0, 0, sm, 6'(r), 6'(c)));
          exp_q.push_back(vec(0, 1, 0, 0, 0, 0, sm, 6'(r), 6'(c)));
        end
    if (with_done) exp_q.push_back(vec(0, 1, 0, 0, 0, 1, sm, 6'(rl), 6'(cl)));
  endfunction

  task automatic run_scan(input int rf, input int rl, input int cf, input int cl,
                          input int p, input int d, input logic sm, input logic lp,
                          input int stop_at);
    bit valid, lp_act;
    int n, busy_cnt, stop_idx, dots;
    valid  = (rf <= rl) && (rl < 48) && (cf <= cl) && (cl < 48);
    lp_act = lp && LOOP_EN;
    row_first = 6'(rf); row_last = 6'(rl); col_first = 6'(cf); col_last = 6'(cl);
    pulse_cycles = 16'(p); dwell_cycles = 16'(d); sel_mode = sm; loop = lp;
    start = 1'b1; stop = 1'b0;
    step();
    start = 1'b0;
    if (!valid) begin
      check("cfg_err", dut_vec(), vec(1, 0, 0, 0, 0, 0, last_rcs, last_row, last_col));
      step();
      check("cfg_clear", dut_vec(), vec(0, 0, 0, 0, 0, 0, last_rcs, last_row, last_col));
      return;
    end
    build(rf, rl, cf, cl, p, d, sm, lp_act ? 3 : 1, !lp_act);
    stop_idx = stop_at;
    if (lp_act && stop_idx < 0) stop_idx = exp_q.size() - 1;
    n = (stop_idx >= 0) ? stop_idx + 1 : exp_q.size();
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      check("scan", dut_vec(), exp_q[i]);
      if (busy && !done) busy_cnt++;
      scramble();
      if (i == n - 1) begin
        start = 1'b0;
        stop  = (stop_idx >= 0);
      end
      step();
    end
    stop     = 1'b0;
    last_row = exp_q[n-1][11:6];
    last_col = exp_q[n-1][5:0];
    last_rcs = sm;
    check("idle", dut_vec(), vec(0, 0, 0, 0, 0, 0, last_rcs, last_row, last_col));
    if (stop_idx < 0) begin
      dots = (rl - rf + 1) * (cl - cf + 1);
      check("busy_cycles", busy_cnt, dots * (2 + p + ((d > 1) ? d : 1)));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; sel_mode = 1'b0;
    row_first = '0; row_last = '0; col_first = '0; col_last = '0;
    pulse_cycles = '0; dwell_cycles = '0;
    last_row = '0; last_col = '0; last_rcs = 1'b0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        bit_mem[r][c]  = 1'($urandom);
        data_mem[r][c] = 1'($urandom);
      end
    step(); step();
    check("reset", dut_vec(), '0);
    reset = 1'b0;
    step();
    check("post_reset", dut_vec(), '0);

    for (int r = 2; r <= 3; r++)
      for (int c = 5; c <= 6; c++) begin
        bit_mem[r][c]  = 1'b1;
        data_mem[r][c] = 1'b1;
      end
    run_scan(2, 3, 5, 6, 3, 2, 1'b1, 1'b0, -1);
    bit_mem[2][6] = 1'b0;
    run_scan(2, 3, 5, 6, 3, 2, 1'b0, 1'b0, -1);
    bit_mem[2][6] = 1'b1;
    run_scan(0, 0, 0, 0, 0, 0, 1'b1, 1'b0, -1);
    run_scan(2, 3, 5, 48, 3, 2, 1'b0, 1'b0, -1);
    run_scan(4, 3, 5, 6, 3, 2, 1'b0, 1'b0, -1);
    run_scan(2, 3, 5, 6, 3, 2, 1'b1, 1'b0, 9);
    run_scan(2, 3, 5, 6, 3, 2, 1'b0, 1'b0, -1);
    run_scan(7, 7, 10, 11, 1, 0, 1'b1, 1'b1, -1);

    // stop together with start in IDLE: nothing starts, nothing rejected
    row_first = 6'd1; row_last = 6'd1; col_first = 6'd1; col_last = 6'd1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("stop_start", dut_vec(), vec(0, 0, 0, 0, 0, 0, last_rcs, last_row, last_col));

    for (int t = 0; t < 30; t++) begin
      int rf, rl, cf, cl, p, d, stp, per;
      rf = $urandom_range(0, 47);
      rl = rf + $urandom_range(0, 2);
      cf = $urandom_range(0, 47);
      cl = cf + $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) begin
        int tmp;
        tmp = rf; rf = rl; rl = tmp;
      end
      p   = $urandom_range(0, 4);
      d   = $urandom_range(0, 3);
      per = (rl - rf + 1) * (cl - cf + 1) * (2 + p + ((d > 1) ? d : 1));
      stp = ($urandom_range(0, 4) == 0 && per > 0) ? $urandom_range(0, per - 1) : -1;
      run_scan(rf, rl, cf, cl, p, d, 1'($urandom), ($urandom_range(0, 3) == 0), stp);
    end

    // reset in the middle of a scan
    row_first = 6'd3; row_last = 6'd4; col_first = 6'd3; col_last = 6'd4;
    pulse_cycles = 16'd2; dwell_cycles = 16'd1; sel_mode = 1'b1; loop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    check("reset_mid", dut_vec(), '0);
    reset = 1'b0;
    last_row = '0; last_col = '0; last_rcs = 1'b0;
    run_scan(0, 1, 0, 1, 1, 1, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
